// File: rtl/req_serializer_pkg.sv
// Shared types and helpers for req_serializer: FSM state, default width,
// one-hot to index encoding and population count.
package req_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEFAULT_N = 16;
  // Widest request vector the helper functions accept.
  localparam int MAX_W = 256;

  function automatic int oh_to_idx(input logic [MAX_W-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/req_serializer_onehot_encoder.sv
// Purely combinational one-hot to binary index encoder used by req_serializer.
module onehot_encoder
  import req_serializer_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  onehot_i,
  output logic [IW-1:0] idx_o
);

  assign idx_o = IW'(oh_to_idx(MAX_W'(onehot_i)));

endmodule

// File: rtl/req_serializer.sv
// Captures a request vector and issues one MSB-first grant per handshake.
// Optional macro REQ_SERIALIZER_COUNT_EN adds the pend_cnt popcount output.
module req_serializer
  import req_serializer_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_onehot,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy
`ifdef REQ_SERIALIZER_COUNT_EN
  ,
  output logic [CW-1:0] pend_cnt
`endif
);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask;
  logic         seen;

  // Bit i survives only when no higher bit of pend is set.
  always_comb begin
    mask = '0;
    seen = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      mask[i] = ~seen;
      seen    = seen | pend_q[i];
    end
  end

  assign busy       = (state_q == BUSY);
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = busy;
  assign out_onehot = pend_q & mask;
  assign out_last   = busy && ((pend_q & ~out_onehot) == '0);

  onehot_encoder #(.N(N)) u_enc (
    .onehot_i (out_onehot),
    .idx_o    (out_idx)
  );

`ifdef REQ_SERIALIZER_COUNT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  assign pend_cnt = cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
`ifdef REQ_SERIALIZER_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // An all-zero vector is consumed without leaving IDLE.
        if (in_valid && (in_vec != '0)) begin
          pend_d  = in_vec;
          state_d = BUSY;
`ifdef REQ_SERIALIZER_COUNT_EN
          cnt_d   = CW'(popcount(MAX_W'(in_vec)));
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          pend_d = pend_q & ~out_onehot;
`ifdef REQ_SERIALIZER_COUNT_EN
          cnt_d  = cnt_q - CW'(1);
`endif
          if (out_last) begin
            state_d = IDLE;
            pend_d  = '0;
`ifdef REQ_SERIALIZER_COUNT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
`ifdef REQ_SERIALIZER_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
`ifdef REQ_SERIALIZER_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/req_serializer.md
Name: req_serializer

Overview:
- Downstream companion to the left-priority (MSB-first) one-hot arbiter.
- Captures a full request vector, then issues one grant per handshake, highest set bit first, until the vector is drained.
- Each grant is presented as a one-hot value and a binary index on a valid/ready interface.
- Sits between a request source (e.g. an ALU op-select or bus request collector) and the consumer that services one requester at a time.

Parameters:
- N, 16: width of the request vector; legal range is N >= 2.
- IW, $clog2(N): index width. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request vector is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector; bit i set means requester i is pending.
- out_valid  output  1  a grant is presented.
- out_ready  input  1  consumer accepts the grant.
- out_onehot  output  N  one-hot grant: the highest set bit of the pending vector.
- out_idx  output  IW  binary index of out_onehot.
- out_last  output  1  current grant is the final one for the captured vector.
- busy  output  1  state is BUSY.

Behaviour:
- Clock and reset: one clock domain (clk); reset rst_n is asynchronous, active-low.
- State: a 2-state FSM, IDLE and BUSY, plus the pending register pend[N-1:0].
- Reset values: state=IDLE, pend=0, out_valid=0, out_onehot=0, out_idx=0, out_last=0, busy=0, in_ready=1.
- in_ready equals (state==IDLE). There is no combinational path from in_* to out_*.
- IDLE, on in_valid&&in_ready:
  - If in_vec != 0: pend<=in_vec, go to BUSY.
  - If in_vec == 0: accept and drop the vector, stay IDLE, produce no output.
- BUSY outputs, all decoded from pend only:
  - out_valid=1.
  - out_onehot = pend & cascade mask, where mask[N-1]=1 and mask[i]=mask[i+1] & ~pend[i+1].
  - out_idx = encode(out_onehot).
  - out_last = (pend & ~out_onehot) == 0.
- BUSY, on out_valid&&out_ready: pend <= pend & ~out_onehot.
  - If out_last: go to IDLE; pend becomes 0.
- Stall: while out_ready=0, pend and all out_* hold stable.
- Latency:
  - Vector accepted at edge k gives first grant visible after edge k; the earliest consuming handshake is at edge k+1.
  - Then one grant per cycle with out_ready held high.
  - Last handshake at edge j gives in_ready=1 after edge j; one bubble cycle between vectors.
- Throughput: popcount(in_vec) handshakes per vector. A full vector (all ones) takes N grants, index N-1 down to 0.
- in_valid during BUSY is ignored. The source must hold the vector until in_ready.
- Reset mid-operation: asynchronous return to reset values; any pending grants are discarded and no further out_valid is asserted.

Optional Feature:
- Macro: REQ_SERIALIZER_COUNT_EN.
- Defined:
  - Adds output port pend_cnt, width $clog2(N+1).
  - Registered popcount of pend: loaded with popcount(in_vec) on accept, decremented by 1 on each out handshake, 0 in IDLE and at reset.
  - out_last is unchanged and must equal (pend_cnt==1) while BUSY.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, BUSY).
  - Default N constant.
  - Function for one-hot to index encode.
  - Function for popcount.
- Sub-module: onehot_encoder (N parameter, one-hot in, IW index out, purely combinational).
- The MSB-priority mask stays inline in req_serializer.

Test Plan:
- Priority order: in_vec=16'h15B3 (5555), out_ready=1.
  - Required out_idx sequence: 12,10,8,7,5,4,1,0 on consecutive cycles.
  - out_onehot matches each index; out_last=1 only with idx 0.
  - in_ready=1 the cycle after the final handshake.
- Stall: in_vec=16'h0081, out_ready=0 for 3 cycles.
  - out_valid=1, out_idx=7, out_onehot=16'h0080 held stable.
  - Then out_ready=1 gives idx 7, then idx 0 with out_last=1.
- Empty and single vectors:
  - in_vec=16'h0000: accepted, out_valid stays 0, in_ready stays 1, busy=0.
  - in_vec=16'h8000: one grant, idx 15, out_last=1, return to IDLE.
- Ignore while busy: in_vec=16'h0003 accepted, then in_valid=1 with 16'hFFFF during BUSY.
  - Only idx 1, then idx 0 are issued.
  - 16'hFFFF is accepted only once in_ready=1.
- Reset mid-operation: in_vec=16'hFFFF, rst_n pulsed low after 4 grants (idx 15..12).
  - All outputs return to reset values immediately; no further out_valid.
  - in_ready=1 after rst_n deasserts.
- COUNT_EN build: in_vec=16'hFFFF.
  - pend_cnt reads 16, decrements to 1 alongside out_last=1, then 0 in IDLE.
